data_mem_responder: RTL

//   Data-side memory responder: the slave end of the processor's DataAddr/ReadData/WriteData/

---
 rtl/proc_pkg.sv | 14 +
 rtl/data_ram.sv | 40 ++++
 rtl/data_mem_responder.sv | 99 +++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared processor package: global widths and the
// data-side responder state encoding.
package proc_pkg;

    localparam int WORD_SIZE  = 16;
    localparam int DMEM_DEPTH = 256;
    localparam int IMEM_DEPTH = 256;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } RespState;

endpackage

// File: rtl/data_ram.sv
// Single-port synchronous RAM with
// read-before-write data register.
module data_ram
  import proc_pkg::*;
#(
  parameter int    WORD_SIZE = proc_pkg::WORD_SIZE,
  parameter int    DEPTH     = 256,
  parameter int    AW        = 8,
  parameter string INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 re,
  input  logic                 we,
  input  logic [AW-1:0]        addr,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] rdata
);

  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [WORD_SIZE-1:0] rdata_d;
  logic [WORD_SIZE-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-side memory responder: accepts one load/store
// per access and stalls the core for WAIT_STATES cycles.
module data_mem_responder
    import proc_pkg::*;
#(
    parameter int    WORD_SIZE   = proc_pkg::WORD_SIZE,
    parameter int    DEPTH       = 256,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic                 ReadData,
    input  logic                 WriteData,
    input  logic [WORD_SIZE-1:0] DataOut,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataDone,
    output logic                 AccessErr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT =
        CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    RespState      state_d, state_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic          err_d, err_q;
    logic          oor_d, oor_q;
    logic          accept;
    logic          in_range;
    logic          ld_acc;
    logic          st_we;
    logic [WORD_SIZE-1:0] ram_rdata;

    // No aliasing: the full address is compared against DEPTH.
    assign in_range = {1'b0, DataAddr} < (WORD_SIZE + 1)'(DEPTH);
    assign DataDone = (state_q == IDLE);
    assign accept   = Resetn & DataDone & (ReadData | WriteData);
    assign ld_acc   = accept & ReadData;
    assign st_we    = accept & WriteData & in_range;

    data_ram #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (DEPTH),
        .AW        (AW),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (Clock),
        .rst_n (Resetn),
        .re    (ld_acc),
        .we    (st_we),
        .addr  (DataAddr[AW-1:0]),
        .wdata (DataOut),
        .rdata (ram_rdata)
    );

    // Next state: stall counter plus sticky error and load range flag.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q | (accept & ~in_range);
        oor_d   = oor_q;
        if (ld_acc) oor_d = ~in_range;
        unique case (state_q)
            IDLE: begin
                if (accept && WAIT_STATES > 0) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any in-flight stall.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            oor_q   <= oor_d;
        end
    end

    assign DataIn    = oor_q ? '0 : ram_rdata;
    assign AccessErr = err_q;

endmodule
